video_timing_gen: RTL and testbench

//  Generates the raster timing and test-pattern video that feeds video_uut.

---
 rtl/video_timing_gen.sv | 267 ++++++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing and test-pattern source for a CEA 1080p frame (timing is
//   parameterised). It produces the blanking, sync and 24-bit RGB streams that
//   feed video_uut. It also exposes the raster position, a frame-start pulse
//   and a completed-frame counter for downstream overlay stages.
//
// Ports
//   clk_i          pixel clock
//   rst_n_i        asynchronous active-low reset (released synchronously upstream)
//   cen_i          pixel clock enable; nothing advances while low
//   en_i           timing enable; low parks the raster at (0,0) with blanked outputs
//   pattern_sel_i  0=colour bars, 1=solid FF5A43, 2=grid, 3=grey ramp
//   vh_blank_o     {Vblank,Hblank}, active high
//   dvh_sync_o     {D_sync,Vsync,Hsync}; D_sync marks active video
//   vid_rgb_o      R[23:16] G[15:8] B[7:0], zero while blanked
//   hcount_o       pixel index of the pixel currently on the outputs
//   vcount_o       line index of the pixel currently on the outputs
//   frame_start_o  one-clock pulse alongside pixel (0,0)
//   frame_cnt_o    completed-frame counter, wraps at 16 bits
//
// All outputs are registered one enabled cycle behind the raster counters, so
// every output field describes the same pixel.

module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int BAR_W    = 240
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cen_i,
    input  logic        en_i,
    input  logic [1:0]  pattern_sel_i,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [23:0] vid_rgb_o,
    output logic [11:0] hcount_o,
    output logic [10:0] vcount_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_C    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG_C   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST_C   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_C    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG_C   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_C   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST_C = 12'(BAR_W - 1);
    localparam logic        HS_ON_C    = (HS_POL != 0);
    localparam logic        VS_ON_C    = (VS_POL != 0);
    localparam logic [2:0]  SYNC_IDLE_C = {1'b0, ~VS_ON_C, ~HS_ON_C};

    // Colour-bar palette, left to right.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Raster state
    logic [11:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic [11:0] bar_sub_q, bar_sub_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Output registers
    logic [1:0]  vh_blank_q, vh_blank_d;
    logic [2:0]  dvh_sync_q, dvh_sync_d;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        frame_start_q, frame_start_d;

    // Decoded view of the current counter position
    logic        at_origin_s;
    logic [1:0]  pat_eff_s;
    logic        hblank_s;
    logic        vblank_s;
    logic        hsync_s;
    logic        vsync_s;
    logic        active_s;
    logic [23:0] pix_s;

    // Decode blanking, sync and pattern colour for the pixel at (h_q, v_q).
    always_comb begin
        at_origin_s = (h_q == 12'd0) && (v_q == 11'd0);
        // The pattern is latched at the origin; the origin pixel itself must
        // already use the freshly sampled selection.
        if (at_origin_s) begin
            pat_eff_s = pattern_sel_i;
        end else begin
            pat_eff_s = pat_q;
        end
        hblank_s = (h_q >= H_ACT_C);
        vblank_s = (v_q >= V_ACT_C);
        active_s = !hblank_s && !vblank_s;
        if ((h_q >= HS_BEG_C) && (h_q < HS_END_C)) begin
            hsync_s = HS_ON_C;
        end else begin
            hsync_s = ~HS_ON_C;
        end
        if ((v_q >= VS_BEG_C) && (v_q < VS_END_C)) begin
            vsync_s = VS_ON_C;
        end else begin
            vsync_s = ~VS_ON_C;
        end
        case (pat_eff_s)
            2'd0: pix_s = bar_colour(bar_idx_q);
            2'd1: pix_s = 24'hFF5A43;
            2'd2: begin
                if ((h_q[5:0] == 6'd0) || (v_q[5:0] == 6'd0)) begin
                    pix_s = 24'hFFFFFF;
                end else begin
                    pix_s = 24'h000000;
                end
            end
            2'd3:    pix_s = {h_q[10:3], h_q[10:3], h_q[10:3]};
            default: pix_s = 24'h000000;
        endcase
    end

    // Next raster position, bar sub-counters, pattern latch and frame count.
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        bar_sub_d   = bar_sub_q;
        bar_idx_d   = bar_idx_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        if (cen_i) begin
            if (!en_i) begin
                // Park at the origin; an aborted frame is not counted.
                h_d       = 12'd0;
                v_d       = 11'd0;
                bar_sub_d = 12'd0;
                bar_idx_d = 3'd0;
            end else begin
                if (at_origin_s) begin
                    pat_d = pattern_sel_i;
                end else begin
                    pat_d = pat_q;
                end
                if (h_q == H_LAST_C) begin
                    h_d       = 12'd0;
                    bar_sub_d = 12'd0;
                    bar_idx_d = 3'd0;
                    if (v_q == V_LAST_C) begin
                        v_d         = 11'd0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        v_d = v_q + 11'd1;
                    end
                end else begin
                    h_d = h_q + 12'd1;
                    // Bar index advances every BAR_W pixels without a divider.
                    if (bar_sub_q == BAR_LAST_C) begin
                        bar_sub_d = 12'd0;
                        bar_idx_d = bar_idx_q + 3'd1;
                    end else begin
                        bar_sub_d = bar_sub_q + 12'd1;
                    end
                end
            end
        end else begin
            h_d = h_q;
        end
    end

    // Next output word: capture the decoded pixel, or force idle values while disabled.
    always_comb begin
        vh_blank_d    = vh_blank_q;
        dvh_sync_d    = dvh_sync_q;
        rgb_d         = rgb_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        // The frame-start pulse lasts one clock even when cen_i stays low after it.
        frame_start_d = 1'b0;
        if (cen_i) begin
            if (en_i) begin
                vh_blank_d    = {vblank_s, hblank_s};
                dvh_sync_d    = {active_s, vsync_s, hsync_s};
                if (active_s) begin
                    rgb_d = pix_s;
                end else begin
                    rgb_d = 24'h000000;
                end
                hcount_d      = h_q;
                vcount_d      = v_q;
                frame_start_d = at_origin_s;
            end else begin
                vh_blank_d = 2'b11;
                dvh_sync_d = SYNC_IDLE_C;
                rgb_d      = 24'h000000;
                hcount_d   = 12'd0;
                vcount_d   = 11'd0;
            end
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q           <= 12'd0;
            v_q           <= 11'd0;
            bar_sub_q     <= 12'd0;
            bar_idx_q     <= 3'd0;
            pat_q         <= 2'd0;
            frame_cnt_q   <= 16'd0;
            vh_blank_q    <= 2'b11;
            dvh_sync_q    <= SYNC_IDLE_C;
            rgb_q         <= 24'h000000;
            hcount_q      <= 12'd0;
            vcount_q      <= 11'd0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            bar_sub_q     <= bar_sub_d;
            bar_idx_q     <= bar_idx_d;
            pat_q         <= pat_d;
            frame_cnt_q   <= frame_cnt_d;
            vh_blank_q    <= vh_blank_d;
            dvh_sync_q    <= dvh_sync_d;
            rgb_q         <= rgb_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vh_blank_o    = vh_blank_q;
    assign dvh_sync_o    = dvh_sync_q;
    assign vid_rgb_o     = rgb_q;
    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen on a reduced raster (152 x 25) so that
// several complete frames fit in a short run. A behavioural model pushes the
// expected output word for every enabled clock; the word is popped and compared
// once the registered outputs settle.

module tb_video_timing_gen;

    localparam int HA = 128;
    localparam int HF = 8;
    localparam int HS = 4;
    localparam int HB = 12;
    localparam int VA = 16;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 4;
    localparam int BW = 16;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cen_i;
    logic        en_i;
    logic [1:0]  pattern_sel_i;
    logic [1:0]  vh_blank_o;
    logic [2:0]  dvh_sync_o;
    logic [23:0] vid_rgb_o;
    logic [11:0] hcount_o;
    logic [10:0] vcount_o;
    logic        frame_start_o;
    logic [15:0] frame_cnt_o;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .BAR_W(BW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cen_i        (cen_i),
        .en_i         (en_i),
        .pattern_sel_i(pattern_sel_i),
        .vh_blank_o   (vh_blank_o),
        .dvh_sync_o   (dvh_sync_o),
        .vid_rgb_o    (vid_rgb_o),
        .hcount_o     (hcount_o),
        .vcount_o     (vcount_o),
        .frame_start_o(frame_start_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [79:0] exp_q[$];
    logic [79:0] last_exp;
    int          mh;
    int          mv;
    logic [1:0]  mpat;
    logic [15:0] mfc;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Word layout: {pad, vh_blank[68:67], dvh_sync[66:64], rgb[63:40], h[39:28], v[27:17], fs[16], fcnt[15:0]}
    function automatic logic [79:0] pack(input logic [1:0] vb, input logic [2:0] ds,
                                         input logic [23:0] rgb, input logic [11:0] h,
                                         input logic [10:0] v, input logic fs,
                                         input logic [15:0] fc);
        return {11'd0, vb, ds, rgb, h, v, fs, fc};
    endfunction

    function automatic logic [79:0] dut_vec();
        return pack(vh_blank_o, dvh_sync_o, vid_rgb_o, hcount_o, vcount_o, frame_start_o, frame_cnt_o);
    endfunction

    function automatic logic [79:0] model_pixel(input int h, input int v, input logic [1:0] pat,
                                                input logic [15:0] fc);
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic [7:0]  r8;
        hb = (h >= HA);
        vb = (v >= VA);
        hs = (h >= HA + HF) && (h < HA + HF + HS);
        vs = (v >= VA + VF) && (v < VA + VF + VS);
        de = !hb && !vb;
        r8 = 8'((h >> 3) & 255);
        if (!de) begin
            rgb = 24'h000000;
        end else begin
            case (pat)
                2'd0:    rgb = bar_tab[3'(h / BW)];
                2'd1:    rgb = 24'hFF5A43;
                2'd2:    rgb = ((h % 64 == 0) || (v % 64 == 0)) ? 24'hFFFFFF : 24'h000000;
                default: rgb = {r8, r8, r8};
            endcase
        end
        return pack({vb, hb}, {de, vs, hs}, rgb, 12'(h), 11'(v), (h == 0) && (v == 0), fc);
    endfunction

    task automatic model_push(input bit e, input logic [1:0] p);
        logic [79:0] ev;
        if (!e) begin
            ev = pack(2'b11, 3'b000, 24'h0, 12'd0, 11'd0, 1'b0, mfc);
            mh = 0;
            mv = 0;
        end else begin
            if (mh == 0 && mv == 0) mpat = p;
            if (mh == HT - 1 && mv == VT - 1) mfc = mfc + 16'd1;
            ev = model_pixel(mh, mv, mpat, mfc);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        exp_q.push_back(ev);
    endtask

    // One clock: drive inputs, let the model predict, then compare the settled outputs.
    task automatic step(input bit c, input bit e, input logic [1:0] p);
        logic [79:0] want;
        cen_i         = c;
        en_i          = e;
        pattern_sel_i = p;
        @(posedge clk_i);
        if (c) model_push(e, p);
        #1;
        if (c) begin
            want = exp_q.pop_front();
        end else begin
            want     = last_exp;
            want[16] = 1'b0;
        end
        last_exp = want;
        chk("pix", dut_vec(), want);
        if (c && e && mpat == 2'd0 && want[27:17] == 11'd3) begin
            if (want[39:28] == 12'd15)  chk("bar_h15", 80'(vid_rgb_o), 80'(24'hFFFFFF));
            if (want[39:28] == 12'd16)  chk("bar_h16", 80'(vid_rgb_o), 80'(24'hFFFF00));
            if (want[39:28] == 12'd127) chk("bar_h127", 80'(vid_rgb_o), 80'(24'h000000));
        end
        if (c && e && mpat == 2'd2 && want[27:17] == 11'd10) begin
            if (want[39:28] == 12'd64) chk("grid_64_10", 80'(vid_rgb_o), 80'(24'hFFFFFF));
            if (want[39:28] == 12'd65) chk("grid_65_10", 80'(vid_rgb_o), 80'(24'h000000));
        end
        @(negedge clk_i);
    endtask

    task automatic run_to(input int th, input int tv, input logic [1:0] p);
        for (int i = 0; i < HT * VT + 4; i++) begin
            step(1'b1, 1'b1, p);
            if (mh == th && mv == tv) break;
        end
    endtask

    int hb_cnt;
    int hs_cnt;
    int first_hs;
    int fs_cnt;

    initial begin
        rst_n_i       = 1'b0;
        cen_i         = 1'b0;
        en_i          = 1'b0;
        pattern_sel_i = 2'd0;
        mh            = 0;
        mv            = 0;
        mpat          = 2'd0;
        mfc           = 16'd0;
        last_exp      = pack(2'b11, 3'b000, 24'h0, 12'd0, 11'd0, 1'b0, 16'd0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_blank", 80'(vh_blank_o), 80'(2'b11));
        chk("rst_sync", 80'(dvh_sync_o), 80'(3'b000));
        chk("rst_rgb", 80'(vid_rgb_o), 80'(24'h0));
        chk("rst_fs", 80'(frame_start_o), 80'(1'b0));
        chk("rst_fcnt", 80'(frame_cnt_o), 80'(16'd0));
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // First output after release is pixel (0,0) of a bar frame.
        step(1'b1, 1'b1, 2'd0);
        chk("first_fs", 80'(frame_start_o), 80'(1'b1));
        chk("first_dsync", 80'(dvh_sync_o[2]), 80'(1'b1));
        chk("first_blank", 80'(vh_blank_o), 80'(2'b00));
        chk("first_rgb", 80'(vid_rgb_o), 80'(24'hFFFFFF));
        repeat (HT * VT - 1) step(1'b1, 1'b1, 2'd0);
        chk("fcnt_1", 80'(frame_cnt_o), 80'(16'd1));

        // Measure one line of horizontal timing.
        hb_cnt   = 0;
        hs_cnt   = 0;
        first_hs = -1;
        for (int i = 0; i < HT; i++) begin
            step(1'b1, 1'b1, 2'd0);
            if (vh_blank_o[0]) hb_cnt++;
            if (dvh_sync_o[0]) begin
                if (first_hs < 0) first_hs = i;
                hs_cnt++;
            end
        end
        chk("hblank_len", 80'(hb_cnt), 80'(HT - HA));
        chk("hsync_len", 80'(hs_cnt), 80'(HS));
        chk("hsync_pos", 80'(first_hs), 80'(HA + HF));

        // Grid requested mid-frame: bars continue until the next frame.
        run_to(0, 0, 2'd2);
        run_to(0, 12, 2'd2);
        run_to(0, 0, 2'd2);
        chk("fcnt_3", 80'(frame_cnt_o), 80'(16'd3));

        // Ramp frame with cen_i alternating.
        fs_cnt = 0;
        for (int i = 0; i < HT * VT + 4; i++) begin
            step(1'b1, 1'b1, 2'd3);
            if (frame_start_o) fs_cnt++;
            step(1'b0, 1'b1, 2'd3);
            if (frame_start_o) fs_cnt++;
            if (mh == 0 && mv == 0) break;
        end
        chk("fs_width", 80'(fs_cnt), 80'(1));
        chk("fcnt_4", 80'(frame_cnt_o), 80'(16'd4));

        // Abort a solid-colour frame with en_i low for 10 cycles.
        run_to(40, 10, 2'd1);
        repeat (10) step(1'b1, 1'b0, 2'd1);
        chk("off_blank", 80'(vh_blank_o), 80'(2'b11));
        chk("off_rgb", 80'(vid_rgb_o), 80'(24'h0));
        chk("off_fcnt", 80'(frame_cnt_o), 80'(16'd4));
        step(1'b1, 1'b1, 2'd1);
        chk("restart_fs", 80'(frame_start_o), 80'(1'b1));
        chk("restart_pos", 80'({hcount_o, vcount_o}), 80'(23'd0));
        chk("restart_rgb", 80'(vid_rgb_o), 80'(24'hFF5A43));
        repeat (99) step(1'b1, 1'b1, 2'd0);
        chk("pat_hold", 80'(vid_rgb_o), 80'(24'hFF5A43));
        run_to(1, 0, 2'd0);
        chk("pat_next", 80'(vid_rgb_o), 80'(24'hFFFFFF));
        chk("fcnt_5", 80'(frame_cnt_o), 80'(16'd5));
        repeat (20) step(1'b1, 1'b1, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
